// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin arbiter + APB master sharing one slave between NREQ requesters.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles without PREADY.
`default_nettype none

module apb_rr_master #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ-1:0]   REQ_WRITE,
  input  logic [NREQ*32-1:0] REQ_ADDR,
  input  logic [NREQ*32-1:0] REQ_WDATA,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   DONE,
  output logic [31:0]       RDATA,
  output logic              ERR,
  output logic              BUSY,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [31:0]       PADDR,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_rr_master: NREQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   last_gnt, last_gnt_n;
  logic [IW-1:0]   winner, cand;
  logic            found;
  logic [NREQ-1:0] gnt_n, done_n;
  logic [31:0]     rdata_n, paddr_n, pwdata_n;
  logic            err_n, busy_n, psel_n, penable_n, pwrite_n;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
`endif

  // Search starts just above the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = last_gnt;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_gnt) + i) % NREQ);
      if (!found && REQ[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    last_gnt_n = last_gnt;
    gnt_n      = '0;
    done_n     = '0;
    err_n      = 1'b0;
    rdata_n    = RDATA;
    psel_n     = PSEL;
    penable_n  = PENABLE;
    pwrite_n   = PWRITE;
    paddr_n    = PADDR;
    pwdata_n   = PWDATA;
`ifdef APB_TIMEOUT_EN
    cnt_n      = cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n[winner] = 1'b1;
          psel_n        = 1'b1;
          penable_n     = 1'b0;
          pwrite_n      = REQ_WRITE[winner];
          paddr_n       = REQ_ADDR[winner*32 +: 32];
          pwdata_n      = REQ_WDATA[winner*32 +: 32];
          last_gnt_n    = winner;
          state_n       = SETUP;
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        state_n   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_n     = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          psel_n           = 1'b0;
          penable_n        = 1'b0;
          done_n[last_gnt] = 1'b1;
          state_n          = IDLE;
          if (!PWRITE) rdata_n = PRDATA;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          psel_n           = 1'b0;
          penable_n        = 1'b0;
          done_n[last_gnt] = 1'b1;
          err_n            = 1'b1;
          state_n          = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state    <= IDLE;
      last_gnt <= IW'(NREQ - 1);
      GNT      <= '0;
      DONE     <= '0;
      RDATA    <= '0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
`ifdef APB_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_n;
      last_gnt <= last_gnt_n;
      GNT      <= gnt_n;
      DONE     <= done_n;
      RDATA    <= rdata_n;
      ERR      <= err_n;
      BUSY     <= busy_n;
      PSEL     <= psel_n;
      PENABLE  <= penable_n;
      PWRITE   <= pwrite_n;
      PADDR    <= paddr_n;
      PWDATA   <= pwdata_n;
`ifdef APB_TIMEOUT_EN
      cnt      <= cnt_n;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master with a 4-register APB slave model and a DONE scoreboard.
`default_nettype none

module tb_apb_rr_master;
  localparam int NREQ = 2;

  logic                PCLK = 1'b0;
  logic                PRESETn;
  logic [NREQ-1:0]     REQ, REQ_WRITE;
  logic [NREQ*32-1:0]  REQ_ADDR, REQ_WDATA;
  logic [NREQ-1:0]     GNT, DONE;
  logic [31:0]         RDATA, PADDR, PWDATA, PRDATA;
  logic                ERR, BUSY, PSEL, PENABLE, PWRITE, PREADY;

  int checks = 0;
  int fails  = 0;

  apb_rr_master #(.NREQ(NREQ), .TIMEOUT_CYCLES(3)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .GNT(GNT), .DONE(DONE),
    .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Slave: registers PREADY wait_cfg+1 cycles after PENABLE, ID/date/surname/name registers.
  logic [31:0] sregs [4];
  int          wait_cfg = 0;
  bit          never_ready = 1'b0;
  int          wcnt;

  always @(posedge PCLK) begin
    if (!PRESETn) begin
      sregs[0] <= 32'h0000_A5A1;
      sregs[1] <= 32'h2024_0101;
      sregs[2] <= 32'h534D_4954;
      sregs[3] <= 32'h4A4F_484E;
      PREADY   <= 1'b0;
      PRDATA   <= '0;
      wcnt     <= 0;
    end else begin
      PREADY <= 1'b0;
      if (PSEL && PENABLE && !PREADY && !never_ready) begin
        if (wcnt >= wait_cfg) begin
          PREADY <= 1'b1;
          wcnt   <= 0;
          PRDATA <= sregs[PADDR[3:2]];
          if (PWRITE) sregs[PADDR[3:2]] <= PWDATA;
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  typedef struct {
    int          idx;
    bit          rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic set_req(input int i, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    REQ[i]               = 1'b1;
    REQ_WRITE[i]         = wr;
    REQ_ADDR[32*i +: 32] = addr;
    REQ_WDATA[32*i +: 32] = data;
  endtask

  task automatic apply_reset();
    PRESETn = 1'b0;
    REQ = '0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic wait_gnt(output int cyc, output logic [NREQ-1:0] g);
    cyc = 0;
    g   = '0;
    repeat (50) begin
      @(negedge PCLK);
      cyc++;
      if (GNT != '0) begin
        g = GNT;
        return;
      end
    end
  endtask

  task automatic wait_done(output int cyc, output logic [NREQ-1:0] d, output logic e, output logic [31:0] r);
    cyc = 0;
    d   = '0;
    e   = 1'b0;
    r   = '0;
    repeat (50) begin
      @(negedge PCLK);
      cyc++;
      if (DONE != '0) begin
        d = DONE;
        e = ERR;
        r = RDATA;
        return;
      end
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    repeat (2) @(negedge PCLK);
    checks++;
    if ({GNT, DONE, ERR, BUSY, PSEL, PENABLE, PWRITE} !== '0)
      begin fails++; $display("FAIL reset_ctrl: got %b required 0", {GNT, DONE, ERR, BUSY, PSEL, PENABLE, PWRITE}); end
    checks++;
    if ({RDATA, PADDR, PWDATA} !== '0)
      begin fails++; $display("FAIL reset_data: got %h required 0", {RDATA, PADDR, PWDATA}); end
    PRESETn = 1'b1;
  endtask

  task automatic test_single_write();
    int c; logic [NREQ-1:0] g, d; logic e; logic [31:0] r; exp_t x;
    apply_reset();
    set_req(0, 1'b1, 32'h4, 32'h1203_2024);
    exp_q.push_back('{0, 1'b0, 32'h0});
    wait_gnt(c, g);
    REQ = '0;
    checks++;
    if (g !== 2'b01) begin fails++; $display("FAIL sw_gnt: got %b required 01", g); end
    checks++;
    if ({PSEL, PENABLE, BUSY, PWRITE} !== 4'b1011)
      begin fails++; $display("FAIL sw_setup: got %b required 1011", {PSEL, PENABLE, BUSY, PWRITE}); end
    checks++;
    if ({PADDR, PWDATA} !== {32'h4, 32'h1203_2024})
      begin fails++; $display("FAIL sw_addr: got %h required %h", {PADDR, PWDATA}, {32'h4, 32'h1203_2024}); end
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin fails++; $display("FAIL sw_access: got %b required 11", {PSEL, PENABLE}); end
    wait_done(c, d, e, r);
    // DONE lands three cycles after GNT; one of those was consumed above.
    checks++;
    if (c !== 2) begin fails++; $display("FAIL sw_latency: got %0d required 2", c); end
    x = exp_q.pop_front();
    checks++;
    if (d !== NREQ'(1) << x.idx) begin fails++; $display("FAIL sw_done: got %b required %0d", d, x.idx); end
    checks++;
    if ({e, PSEL, PENABLE} !== 3'b000) begin fails++; $display("FAIL sw_err_idle: got %b required 000", {e, PSEL, PENABLE}); end
    checks++;
    if (sregs[1] !== 32'h1203_2024) begin fails++; $display("FAIL sw_slave: got %h required 12032024", sregs[1]); end
  endtask

  task automatic test_write_read();
    int c; logic [NREQ-1:0] g, d; logic e; logic [31:0] r; exp_t x;
    apply_reset();
    set_req(0, 1'b1, 32'h8, 32'h4956_414E);
    exp_q.push_back('{0, 1'b0, 32'h0});
    wait_gnt(c, g);
    REQ = '0;
    wait_done(c, d, e, r);
    x = exp_q.pop_front();
    checks++;
    if (d !== NREQ'(1) << x.idx) begin fails++; $display("FAIL wr_done: got %b required %0d", d, x.idx); end
    checks++;
    if (r !== 32'h0) begin fails++; $display("FAIL wr_rdata_kept: got %h required 0", r); end
    set_req(0, 1'b0, 32'h8, 32'h0);
    exp_q.push_back('{0, 1'b1, 32'h4956_414E});
    wait_gnt(c, g);
    REQ = '0;
    checks++;
    if ({g, PWRITE} !== 3'b010) begin fails++; $display("FAIL rd_gnt_pwrite: got %b required 010", {g, PWRITE}); end
    wait_done(c, d, e, r);
    x = exp_q.pop_front();
    checks++;
    if (d !== NREQ'(1) << x.idx || r !== x.data)
      begin fails++; $display("FAIL rd_data: got done=%b rdata=%h required done idx %0d rdata=%h", d, r, x.idx, x.data); end
  endtask

  task automatic test_contention();
    int c; logic [NREQ-1:0] g, d; logic e; logic [31:0] r; exp_t x;
    int order[4];
    order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;
    apply_reset();
    set_req(0, 1'b1, 32'h0, 32'hAAAA_0000);
    set_req(1, 1'b1, 32'h4, 32'hBBBB_1111);
    for (int k = 0; k < 4; k++) exp_q.push_back('{order[k], 1'b0, 32'h0});
    for (int k = 0; k < 4; k++) begin
      wait_gnt(c, g);
      checks++;
      if (g !== NREQ'(1) << order[k]) begin fails++; $display("FAIL cont_gnt%0d: got %b required %0d", k, g, order[k]); end
      if (k > 0) begin
        checks++;
        if (c !== 1) begin fails++; $display("FAIL cont_spacing%0d: got %0d required 1", k, c); end
      end
      wait_done(c, d, e, r);
      if (k == 3) REQ = '0;
      x = exp_q.pop_front();
      checks++;
      if (d !== NREQ'(1) << x.idx) begin fails++; $display("FAIL cont_done%0d: got %b required %0d", k, d, x.idx); end
    end
  endtask

  task automatic test_reset_mid();
    int c; logic [NREQ-1:0] g, d; logic e; logic [31:0] r; exp_t x;
    apply_reset();
    set_req(0, 1'b1, 32'hC, 32'h1111_2222);
    wait_gnt(c, g);
    REQ = '0;
    @(negedge PCLK);
    checks++;
    if (PENABLE !== 1'b1) begin fails++; $display("FAIL mid_penable: got %b required 1", PENABLE); end
    set_req(1, 1'b0, 32'h0, 32'h0);
    PRESETn = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, DONE, ERR, BUSY} !== '0)
      begin fails++; $display("FAIL mid_abort: got %b required 0", {PSEL, PENABLE, DONE, ERR, BUSY}); end
    PRESETn = 1'b1;
    exp_q.push_back('{1, 1'b1, 32'h0000_A5A1});
    wait_gnt(c, g);
    REQ = '0;
    checks++;
    if (g !== 2'b10) begin fails++; $display("FAIL mid_regrant: got %b required 10", g); end
    wait_done(c, d, e, r);
    x = exp_q.pop_front();
    checks++;
    if (d !== NREQ'(1) << x.idx || r !== x.data)
      begin fails++; $display("FAIL mid_done: got done=%b rdata=%h required idx %0d rdata=%h", d, r, x.idx, x.data); end
  endtask

  task automatic test_wait_states();
    int c, n, bad; logic [NREQ-1:0] g, d; logic e; logic [31:0] r; exp_t x;
    apply_reset();
    wait_cfg = 5;
    set_req(1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    exp_q.push_back('{1, 1'b0, 32'h0});
    wait_gnt(c, g);
    REQ = '0;
    checks++;
    if (g !== 2'b10) begin fails++; $display("FAIL ws_gnt: got %b required 10", g); end
    @(negedge PCLK);
    n = 0; bad = 0;
    for (int k = 0; k < 30 && !PREADY; k++) begin
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, DONE} !== {3'b111, 32'h8, 32'hDEAD_BEEF, 2'b00}) bad++;
      @(negedge PCLK);
      n++;
    end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL ws_stable: got %0d unstable cycles required 0", bad); end
    checks++;
    if (n !== 6 || PREADY !== 1'b1) begin fails++; $display("FAIL ws_pready: got %0d cycles ready=%b required 6 ready=1", n, PREADY); end
    @(negedge PCLK);
    x = exp_q.pop_front();
    checks++;
    if (DONE !== NREQ'(1) << x.idx || PSEL !== 1'b0)
      begin fails++; $display("FAIL ws_done: got done=%b psel=%b required idx %0d psel=0", DONE, PSEL, x.idx); end
    checks++;
    if (sregs[2] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ws_slave: got %h required deadbeef", sregs[2]); end
    wait_cfg = 0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int c; logic [NREQ-1:0] g, d; logic e; logic [31:0] r; exp_t x;
    apply_reset();
    set_req(0, 1'b0, 32'h8, 32'h0);
    wait_gnt(c, g);
    REQ = '0;
    wait_done(c, d, e, r);
    checks++;
    if (r !== 32'h534D_4954) begin fails++; $display("FAIL to_preload: got %h required 534d4954", r); end
    never_ready = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back('{0, 1'b1, 32'h534D_4954});
    wait_gnt(c, g);
    REQ = '0;
    wait_done(c, d, e, r);
    x = exp_q.pop_front();
    checks++;
    if (c !== 4) begin fails++; $display("FAIL to_latency: got %0d required 4", c); end
    checks++;
    if (d !== NREQ'(1) << x.idx || e !== 1'b1 || r !== x.data || PSEL !== 1'b0)
      begin fails++; $display("FAIL to_abort: got done=%b err=%b rdata=%h psel=%b required idx %0d err=1 rdata=%h", d, e, r, PSEL, x.idx, x.data); end
    never_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_write_read();
    test_contention();
    test_reset_mid();
    test_wait_states();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_left: got %0d required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
